// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer port arbiter: queued pixel writes and display reads share
// one memory port; a starvation counter forces a write after a read run.
module frame_buffer_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        mainClk,
   input  logic        nreset,
   input  logic        wrValid,
   input  logic [9:0]  wrX,
   input  logic [8:0]  wrY,
   input  logic [3:0]  wrData,
   output logic        wrReady,
   input  logic        rdReq,
   input  logic [9:0]  rdX,
   input  logic [8:0]  rdY,
   output logic        rdReady,
   output logic        rdValid,
   output logic [3:0]  rdData,
   output logic [18:0] memAddr,
   output logic        memWe,
   output logic [3:0]  memWdata,
   input  logic [3:0]  memRdata,
   output logic        wrDropped,
   output logic        frameDone
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_RD,
      GNT_WR
   } gnt_t;

   logic [18:0]   qAddr [FIFO_DEPTH];
   logic [3:0]    qData [FIFO_DEPTH];
   logic          qLast [FIFO_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [SW-1:0] starveCnt;
   logic          rdPend;

   logic          empty;
   logic          full;
   logic          wrInRange;
   logic          wrLast;
   logic          push;
   logic          drop;
   logic [18:0]   wrAddr;
   logic [18:0]   rdAddr;
   logic          starved;
   gnt_t          gnt;
   logic          rdGrant;
   logic          wrGrant;

   assign empty     = (count == '0);
   assign full      = (count == CW'(FIFO_DEPTH));
   assign wrReady   = ~full;
   assign wrInRange = (wrX < 10'd640) && (wrY < 9'd480);
   assign wrLast    = (wrX == 10'd639) && (wrY == 9'd479);
   assign push      = wrValid & wrReady & wrInRange;
   assign drop      = wrValid & wrReady & ~wrInRange;

   // full 19-bit products; 479*640+639 = 307199 fits
   assign wrAddr = ({10'd0, wrY} * 19'd640) + {9'd0, wrX};
   assign rdAddr = ({10'd0, rdY} * 19'd640) + {9'd0, rdX};

   assign starved = (starveCnt >= SW'(STARVE_LIMIT));

   always_comb begin
      gnt = GNT_IDLE;
      if (rdReq && (empty || !starved)) begin
         gnt = GNT_RD;
      end else if (!empty) begin
         gnt = GNT_WR;
      end
   end

   assign rdGrant = (gnt == GNT_RD);
   assign wrGrant = (gnt == GNT_WR);
   assign rdReady = rdGrant;

   always_ff @(posedge mainClk) begin
      if (push) begin
         qAddr[tail] <= wrAddr;
         qData[tail] <= wrData;
         qLast[tail] <= wrLast;
      end
   end

   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= (tail == PW'(FIFO_DEPTH - 1)) ? '0 : tail + 1'b1;
         end
         if (wrGrant) begin
            head <= (head == PW'(FIFO_DEPTH - 1)) ? '0 : head + 1'b1;
         end
         if (push && !wrGrant) begin
            count <= count + 1'b1;
         end else if (!push && wrGrant) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         starveCnt <= '0;
      end else if (wrGrant || empty) begin
         starveCnt <= '0;
      end else if (rdGrant && !starved) begin
         starveCnt <= starveCnt + 1'b1;
      end
   end

   always_ff @(posedge mainClk or negedge nreset) begin
      if (!nreset) begin
         memAddr   <= '0;
         memWe     <= 1'b0;
         memWdata  <= '0;
         frameDone <= 1'b0;
         rdPend    <= 1'b0;
         rdValid   <= 1'b0;
         wrDropped <= 1'b0;
      end else begin
         memWe     <= wrGrant;
         frameDone <= wrGrant & qLast[head];
         rdPend    <= rdGrant;
         rdValid   <= rdPend;
         wrDropped <= wrDropped | drop;
         if (wrGrant) begin
            memAddr  <= qAddr[head];
            memWdata <= qData[head];
         end else if (rdGrant) begin
            memAddr <= rdAddr;
         end
      end
   end

   // memory returns data the cycle after the address register loads
   assign rdData = rdValid ? memRdata : 4'd0;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: write table, read latency, starvation
// and mid-operation reset, with a write scoreboard and memory model.
module tb_frame_buffer_arbiter;

   logic        mainClk;
   logic        nreset;
   logic        wrValid;
   logic [9:0]  wrX;
   logic [8:0]  wrY;
   logic [3:0]  wrData;
   logic        wrReady;
   logic        rdReq;
   logic [9:0]  rdX;
   logic [8:0]  rdY;
   logic        rdReady;
   logic        rdValid;
   logic [3:0]  rdData;
   logic [18:0] memAddr;
   logic        memWe;
   logic [3:0]  memWdata;
   logic [3:0]  memRdata;
   logic        wrDropped;
   logic        frameDone;

   int vecs = 0;
   int miss = 0;
   int nAccepted = 0;
   int lastWait = 0;

   typedef struct {
      int          x;
      int          y;
      logic [3:0]  d;
      logic        we;
      logic [18:0] addr;
      logic        fd;
      logic        drop;
   } vec_t;

   typedef struct {
      logic [18:0] addr;
      logic [3:0]  data;
   } wr_t;

   wr_t wq[$];

   logic [3:0] mem [0:524287];

   frame_buffer_arbiter #(
      .FIFO_DEPTH(4),
      .STARVE_LIMIT(4)
   ) dut (
      .mainClk(mainClk),
      .nreset(nreset),
      .wrValid(wrValid),
      .wrX(wrX),
      .wrY(wrY),
      .wrData(wrData),
      .wrReady(wrReady),
      .rdReq(rdReq),
      .rdX(rdX),
      .rdY(rdY),
      .rdReady(rdReady),
      .rdValid(rdValid),
      .rdData(rdData),
      .memAddr(memAddr),
      .memWe(memWe),
      .memWdata(memWdata),
      .memRdata(memRdata),
      .wrDropped(wrDropped),
      .frameDone(frameDone)
   );

   initial mainClk = 1'b0;
   always #5 mainClk = ~mainClk;

   function automatic logic [3:0] pat(input logic [18:0] a);
      return a[3:0] ^ a[11:8] ^ 4'h5;
   endfunction

   initial begin
      for (int i = 0; i < 524288; i++) mem[i] = pat(19'(i));
      memRdata = 4'd0;
   end

   // synchronous-read frame-buffer model
   always @(posedge mainClk) begin
      if (memWe) mem[memAddr] <= memWdata;
      memRdata <= mem[memAddr];
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      vecs++;
      miss++;
      $display("FAIL %s", nm);
   endtask

   task automatic step();
      @(posedge mainClk);
      #1;
   endtask

   task automatic do_write(input int x, input int y, input logic [3:0] d);
      int n;
      wrValid = 1'b1;
      wrX = 10'(x);
      wrY = 9'(y);
      wrData = d;
      n = 0;
      @(negedge mainClk);
      while (!wrReady && n < 100) begin
         @(negedge mainClk);
         n++;
      end
      if (!wrReady) bad("wrReady timeout");
      lastWait = n;
      @(posedge mainClk);
      #1;
      wrValid = 1'b0;
      nAccepted++;
   endtask

   // scoreboard: writes queued on acceptance, reads tracked by latency
   logic        p1 = 1'b0;
   logic        p2 = 1'b0;
   logic [18:0] a1 = '0;
   logic [18:0] a2 = '0;
   logic        expDropped = 1'b0;

   always @(negedge mainClk) begin
      wr_t e;
      if (!nreset) begin
         wq.delete();
         p1 = 1'b0;
         p2 = 1'b0;
         expDropped = 1'b0;
      end else begin
         chk("rdValid latency", rdValid, p2);
         if (p2) chk("rdData", rdData, pat(a2));
         if (p1) begin
            chk("read memAddr", memAddr, a1);
            chk("read memWe", memWe, 0);
         end
         if (memWe) begin
            if (wq.size() == 0) begin
               bad("unexpected memWe");
            end else begin
               e = wq.pop_front();
               chk("write addr", memAddr, e.addr);
               chk("write data", memWdata, e.data);
               chk("frameDone on write", frameDone, e.addr == 19'd307199);
            end
         end else begin
            chk("frameDone idle", frameDone, 0);
         end
         chk("wrDropped", wrDropped, expDropped);
         if (wrValid && wrReady) begin
            if (wrX >= 640 || wrY >= 480) begin
               expDropped = 1'b1;
            end else begin
               e.addr = 19'(int'(wrY) * 640 + int'(wrX));
               e.data = wrData;
               wq.push_back(e);
            end
         end
         p2 = p1;
         a2 = a1;
         p1 = rdReq && rdReady;
         a1 = 19'(int'(rdY) * 640 + int'(rdX));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vec_t tbl [9];
      int base;
      tbl[0] = '{5,    2,   4'hA, 1'b1, 19'd1285,   1'b0, 1'b0};
      tbl[1] = '{0,    0,   4'h3, 1'b1, 19'd0,      1'b0, 1'b0};
      tbl[2] = '{639,  0,   4'h7, 1'b1, 19'd639,    1'b0, 1'b0};
      tbl[3] = '{0,    479, 4'hC, 1'b1, 19'd306560, 1'b0, 1'b0};
      tbl[4] = '{100,  100, 4'h5, 1'b1, 19'd64100,  1'b0, 1'b0};
      tbl[5] = '{639,  479, 4'hF, 1'b1, 19'd307199, 1'b1, 1'b0};
      tbl[6] = '{640,  0,   4'h9, 1'b0, 19'd0,      1'b0, 1'b1};
      tbl[7] = '{0,    480, 4'h1, 1'b0, 19'd0,      1'b0, 1'b1};
      tbl[8] = '{1023, 511, 4'h2, 1'b0, 19'd0,      1'b0, 1'b1};

      nreset = 1'b0;
      wrValid = 1'b0;
      wrX = '0;
      wrY = '0;
      wrData = '0;
      rdReq = 1'b0;
      rdX = '0;
      rdY = '0;

      @(negedge mainClk);
      chk("reset wrReady", wrReady, 1);
      chk("reset memWe", memWe, 0);
      chk("reset memAddr", memAddr, 0);
      chk("reset memWdata", memWdata, 0);
      chk("reset rdValid", rdValid, 0);
      chk("reset rdData", rdData, 0);
      chk("reset wrDropped", wrDropped, 0);
      chk("reset frameDone", frameDone, 0);
      step();
      nreset = 1'b1;
      step();

      // read of the last pixel
      rdReq = 1'b1;
      rdX = 10'd639;
      rdY = 9'd479;
      @(negedge mainClk);
      chk("read rdReady", rdReady, 1);
      step();
      rdReq = 1'b0;
      @(negedge mainClk);
      chk("read N+1 memAddr", memAddr, 307199);
      chk("read N+1 memWe", memWe, 0);
      chk("read N+1 rdValid", rdValid, 0);
      @(negedge mainClk);
      chk("read N+2 rdValid", rdValid, 1);
      chk("read N+2 rdData", rdData, pat(19'd307199));
      @(negedge mainClk);
      chk("read N+3 rdValid", rdValid, 0);

      // single writes into an idle block
      for (int i = 0; i < 9; i++) begin
         step();
         do_write(tbl[i].x, tbl[i].y, tbl[i].d);
         @(negedge mainClk);
         chk("vec early memWe", memWe, 0);
         @(negedge mainClk);
         chk("vec memWe", memWe, tbl[i].we);
         if (tbl[i].we) begin
            chk("vec memAddr", memAddr, tbl[i].addr);
            chk("vec memWdata", memWdata, tbl[i].d);
            chk("vec frameDone", frameDone, tbl[i].fd);
         end
         chk("vec wrDropped", wrDropped, tbl[i].drop);
         @(negedge mainClk);
         chk("vec after memWe", memWe, 0);
         chk("vec after frameDone", frameDone, 0);
         if (tbl[i].we) chk("vec memAddr hold", memAddr, tbl[i].addr);
      end

      // continuous reads with six back-to-back writes
      step();
      rdReq = 1'b1;
      rdX = 10'd3;
      rdY = 9'd7;
      base = nAccepted;
      fork
         begin
            for (int w = 0; w < 6; w++) begin
               do_write(10 + w, 20, 4'(w + 1));
               if (w < 4) chk("wrReady before full", lastWait, 0);
               if (w == 4) chk("wrReady low when full", lastWait != 0, 1);
            end
         end
         begin
            int run;
            int nw;
            int cyc;
            run = 0;
            nw = 0;
            cyc = 0;
            while (nw < 6 && cyc < 400) begin
               @(negedge mainClk);
               cyc++;
               if (nAccepted != base) begin
                  if (rdReady) begin
                     run++;
                  end else begin
                     chk("reads between writes", run, 4);
                     run = 0;
                     nw++;
                  end
               end
            end
            if (nw < 6) bad("starvation write timeout");
         end
      join
      step();
      rdReq = 1'b0;
      repeat (4) @(negedge mainClk);
      chk("all writes landed", wq.size(), 0);
      for (int i = 0; i < 6; i++) begin
         chk("memory contents", mem[12810 + i], i + 1);
      end

      // reset with queued writes and a read in flight
      step();
      rdReq = 1'b1;
      rdX = 10'd3;
      rdY = 9'd7;
      do_write(50, 60, 4'h1);
      do_write(51, 60, 4'h2);
      do_write(52, 60, 4'h3);
      nreset = 1'b0;
      rdReq = 1'b0;
      @(negedge mainClk);
      chk("mid reset wrReady", wrReady, 1);
      chk("mid reset memWe", memWe, 0);
      chk("mid reset memAddr", memAddr, 0);
      chk("mid reset memWdata", memWdata, 0);
      chk("mid reset rdValid", rdValid, 0);
      chk("mid reset wrDropped", wrDropped, 0);
      chk("mid reset frameDone", frameDone, 0);
      step();
      step();
      nreset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge mainClk);
         chk("post reset memWe", memWe, 0);
         chk("post reset rdValid", rdValid, 0);
         chk("post reset wrReady", wrReady, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frameBufferArbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FIFO_DEPTH, 4, write-queue entries
- STARVE_LIMIT, 4, consecutive read grants before a waiting write is forced
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- mainClk, in, 1, single clock; all logic on rising edge
- nreset, in, 1, asynchronous active-low reset
- wrValid, in, 1, write request from the edge-result path
- wrX, in, 10, write x coordinate
- wrY, in, 9, write y coordinate
- wrData, in, 4, write pixel
- wrReady, out, 1, write queue not full
- rdReq, in, 1, display read request
- rdX, in, 10, read x coordinate
- rdY, in, 9, read y coordinate
- rdReady, out, 1, read accepted this cycle
- rdValid, out, 1, read data valid
- rdData, out, 4, read pixel
- memAddr, out, 19, frame-buffer address (registered)
- memWe, out, 1, frame-buffer write enable (registered)
- memWdata, out, 4, frame-buffer write data (registered)
- memRdata, in, 4, frame-buffer read data; valid one cycle after the registered address
- wrDropped, out, 1, sticky flag: an out-of-range write was discarded
- frameDone, out, 1, one-cycle pulse when a write to (639,479) is issued

Function
REQ-003 Address SHALL be y*640+x, computed at full 19-bit width with no truncation; the maximum value is 307199.
REQ-004 A write SHALL be accepted when wrValid&wrReady; an accepted write with wrX>=640 or wrY>=480 SHALL NOT be queued and SHALL set wrDropped.
REQ-005 In-range accepted writes SHALL be pushed into a FIFO_DEPTH FIFO; wrReady=0 exactly when the FIFO is full.
REQ-006 Writes SHALL issue only from the FIFO head, so a write pushed into an empty FIFO issues no earlier than the next cycle.
REQ-007 Arbitration each cycle: if rdReq and (FIFO empty or starveCnt<STARVE_LIMIT), grant read; else if FIFO not empty, grant write; else idle.
REQ-008 starveCnt SHALL increment on each read grant while the FIFO is non-empty; it SHALL clear on a write grant or when the FIFO is empty; it SHALL saturate at STARVE_LIMIT.
REQ-009 rdReady SHALL equal the read grant combinationally; a request with rdReady=0 SHALL be held by the requester; rdX/rdY are assumed in range.
REQ-010 On a read grant in cycle N, the next edge SHALL load memAddr, memWe=0; rdValid SHALL be 1 in cycle N+2 with rdData=memRdata.
REQ-011 On a write grant in cycle N, the next edge SHALL load memAddr, memWdata, memWe=1 and pop the FIFO head; frameDone SHALL pulse in cycle N+1 when the popped coordinate is (639,479).
REQ-012 On an idle cycle memWe SHALL be 0 next cycle; memAddr SHALL hold its last value.
REQ-013 A push and pop in the same cycle SHALL leave the occupancy unchanged; a push is impossible when full (wrReady=0).
REQ-014 At most one memory operation SHALL issue per cycle; reads are never reordered, and writes leave in acceptance order.
REQ-015 rdValid SHALL never be asserted without a matching grant two cycles earlier; the read pipeline SHALL be two flag stages.

Reset
REQ-016 While nreset=0, the block SHALL hold: FIFO empty, wrReady=1, starveCnt=0, memAddr=0, memWe=0, memWdata=0, rdValid=0, rdData=0, wrDropped=0, frameDone=0.
REQ-017 Reset mid-operation SHALL discard queued writes and in-flight reads; no rdValid or memWe SHALL follow the release of reset for operations accepted before reset.
REQ-018 wrDropped SHALL clear only by reset.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single write (x=5, y=2, data=0xA) into an idle block -> memWe=1, memAddr=1285, memWdata=0xA exactly one issue cycle later.
- Continuous rdReq plus 6 back-to-back writes -> wrReady falls after 4 entries; a write issues after every 4 read grants; all 6 writes land in order.
- Read (x=639, y=479) granted in cycle N -> memAddr=307199 at N+1; rdValid=1 at N+2 with rdData = the memory model value.
- Write with x=640 -> not queued, no memWe, wrDropped=1 and stays 1 until reset.
- Write to (639,479) -> frameDone high for exactly one cycle, aligned with memWe.
- Assert nreset with 3 writes queued and a read in flight -> after release, no memWe, no rdValid, wrReady=1.
